imem_loader: RTL and testbench

Boot-time writer for the processor's instruction memory: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction-memory write port that the fetch unit later reads. It holds the processor core in reset until a complete image has been written, then releases it. It sits between the host byte link and the instruction memory, beside the processor top.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/word_assembler.sv | 36 +++
 rtl/imem_loader.sv | 153 +++++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encoding for the instruction-memory loader
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_WIDTH    = 16;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_WORD = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        HDR0 = ST_HDR0,
        HDR1 = ST_HDR1,
        WORD = ST_WORD,
        CHK  = ST_CHK,
        DONE = ST_DONE,
        ERR  = ST_ERR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - little-endian byte-to-word shift register with byte index
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [23:0] shreg;
    logic [1:0]  idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            idx   <= '0;
        end else if (clear) begin
            shreg <= '0;
            idx   <= '0;
        end else if (byte_valid) begin
            shreg <= {byte_data, shreg[23:8]};
            idx   <= idx + 2'd1;
        end
    end

    // The final byte is merged combinationally so the word is ready on its accept edge.
    assign word       = {byte_data, shreg};
    assign word_ready = byte_valid && (idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader writing a framed byte stream into instruction memory
// Optional trailing XOR checksum byte: LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [32:0]           CAPACITY  = 33'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] BASE_WORD = ADDR_WIDTH'(BASE_ADDR);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t                 state;
    state_t                 state_nxt;
    logic [7:0]             count_lo;
    logic [COUNT_WIDTH-1:0] count;
    logic [COUNT_WIDTH-1:0] word_idx;
    logic [COUNT_WIDTH-1:0] hdr_count;
    logic                   hdr_too_big;
    logic                   hdr_zero;
    logic                   last_word;
    logic                   accept;
    logic                   reload_ok;
    logic                   asm_valid;
    logic [31:0]            asm_word;
    logic                   asm_ready;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum;
`endif

    assign accept      = in_valid && in_ready;
    assign asm_valid   = accept && (state == WORD);
    assign reload_ok   = reload && ((state == DONE) || (state == ERR));
    assign hdr_count   = {in_data, count_lo};
    assign hdr_too_big = 33'(hdr_count) > CAPACITY;
    assign hdr_zero    = (hdr_count == '0);
    assign last_word   = (17'(word_idx) + 17'd1) == 17'(count);

    word_assembler u_word_assembler (
        .clock      (clock),
        .reset      (reset),
        .clear      (reload_ok),
        .byte_valid (asm_valid),
        .byte_data  (in_data),
        .word       (asm_word),
        .word_ready (asm_ready)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state uses in_valid directly; in_ready is a pure state decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            IDLE: state_nxt = HDR0;
            HDR0: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = HDR1;
            end
            HDR1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (hdr_too_big)   state_nxt = ERR;
                    else if (hdr_zero) state_nxt = END_STATE;
                    else               state_nxt = WORD;
                end
            end
            WORD: begin
                in_ready = 1'b1;
                if (asm_ready && last_word) state_nxt = END_STATE;
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = (in_data == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (reload) state_nxt = HDR0;
            end
            ERR: begin
                error = 1'b1;
                if (reload) state_nxt = HDR0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_lo <= '0;
            count    <= '0;
            word_idx <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= BASE_WORD;
            wr_data  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (reload_ok) begin
                word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) csum <= csum ^ in_data;
`endif
                if (accept && (state == HDR0)) count_lo <= in_data;
                if (accept && (state == HDR1)) count <= hdr_count;
                if (asm_ready) begin
                    wr_en    <= 1'b1;
                    wr_data  <= asm_word;
                    wr_addr  <= ADDR_WIDTH'(32'(BASE_ADDR) + 32'(word_idx));
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          reload;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int            vectors = 0;
    int            miscompares = 0;
    logic [7:0]    tb_csum;
    logic [AW-1:0] wa_q[$];
    logic [31:0]   wd_q[$];
    logic [7:0]    tog_bytes [14];

    always #5 clock = ~clock;

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always @(negedge clock) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 20) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        tb_csum  = tb_csum ^ b;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_frame(input logic [15:0] n);
        tb_csum = 8'h00;
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic end_frame;
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum);
`endif
    endtask

    task automatic pulse_reload;
        reload = 1'b1;
        @(posedge clock); #1;
        reload = 1'b0;
    endtask

    task automatic clear_log;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_wr_en"},    {31'b0, wr_en},    32'd0);
        check({tag, "_wr_addr"},  32'(wr_addr),      32'd0);
        check({tag, "_wr_data"},  wr_data,           32'd0);
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
        check({tag, "_done"},     {31'b0, done},     32'd0);
        check({tag, "_error"},    {31'b0, error},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        tb_csum  = 8'h00;
        tog_bytes = '{8'h03, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44,
                      8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        #12;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("idle_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock); #1;
        check("hdr0_in_ready", {31'b0, in_ready}, 32'd1);

        // two-word image
        clear_log();
        start_frame(16'd2);
        send_word(32'h00000013);
        send_word(32'h00100093);
`ifndef LOADER_CHECKSUM_EN
        check("t1_wr_en_with_done", {31'b0, wr_en}, 32'd1);
`endif
        end_frame();
        check("t1_done",     {31'b0, done},     32'd1);
        check("t1_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        check("t1_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock); #1;
        check("t1_wr_en_pulse", {31'b0, wr_en}, 32'd0);
        check("t1_nwrites", 32'(wa_q.size()), 32'd2);
        check("t1_addr0", 32'(wa_q[0]), 32'd0);
        check("t1_data0", wd_q[0], 32'h00000013);
        check("t1_addr1", 32'(wa_q[1]), 32'd1);
        check("t1_data1", wd_q[1], 32'h00100093);

        // reload, then empty image
        pulse_reload();
        check("rl_in_ready", {31'b0, in_ready}, 32'd1);
        check("rl_done",     {31'b0, done},     32'd0);
        check("rl_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        clear_log();
        start_frame(16'd0);
        end_frame();
        check("t2_done",     {31'b0, done},     32'd1);
        check("t2_cpu_hold", {31'b0, cpu_hold}, 32'd0);
        @(posedge clock); #1;
        check("t2_nwrites", 32'(wa_q.size()), 32'd0);

        // oversize count: 257 words into a 256-word memory
        pulse_reload();
        clear_log();
        start_frame(16'd257);
        check("t3_error",    {31'b0, error},    32'd1);
        check("t3_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("t3_in_ready", {31'b0, in_ready}, 32'd0);
        check("t3_done",     {31'b0, done},     32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("t3_error_held", {31'b0, error}, 32'd1);
        check("t3_nwrites", 32'(wa_q.size()), 32'd0);
        pulse_reload();
        check("t3_rl_error",    {31'b0, error},    32'd0);
        check("t3_rl_in_ready", {31'b0, in_ready}, 32'd1);

        // three words with in_valid low every other cycle
        clear_log();
        tb_csum = 8'h00;
        for (int i = 0; i < 14; i++) begin
            send_byte(tog_bytes[i]);
            in_data = 8'hFF;
            @(posedge clock); #1;
        end
        end_frame();
        check("t4_done", {31'b0, done}, 32'd1);
        @(posedge clock); #1;
        check("t4_nwrites", 32'(wa_q.size()), 32'd3);
        check("t4_data0", wd_q[0], 32'hAABBCCDD);
        check("t4_data1", wd_q[1], 32'h11223344);
        check("t4_addr2", 32'(wa_q[2]), 32'd2);
        check("t4_data2", wd_q[2], 32'hDEADBEEF);

        // full capacity: exactly 256 words is legal
        pulse_reload();
        clear_log();
        start_frame(16'd256);
        for (int i = 0; i < 256; i++) send_word({8'(i), 8'(255 - i), 8'h3C, 8'(i)});
        end_frame();
        @(posedge clock); #1;
        check("t5_done",    {31'b0, done},  32'd1);
        check("t5_error",   {31'b0, error}, 32'd0);
        check("t5_nwrites", 32'(wa_q.size()), 32'd256);
        check("t5_addr128", 32'(wa_q[128]), 32'h80);
        check("t5_addr255", 32'(wa_q[255]), 32'hFF);
        check("t5_data255", wd_q[255], 32'hFF003CFF);

        // reset after 6 bytes of a 2-word load
        pulse_reload();
        clear_log();
        start_frame(16'd2);
        send_word(32'hCAFEF00D);
        check("t6_mid_wr_en",   {31'b0, wr_en}, 32'd1);
        check("t6_mid_wr_data", wr_data, 32'hCAFEF00D);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("t6_rst");
        @(negedge clock);
        reset = 1'b0;
        clear_log();
        @(posedge clock); #1;
        start_frame(16'd2);
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        end_frame();
        @(posedge clock); #1;
        check("t6_done",    {31'b0, done}, 32'd1);
        check("t6_nwrites", 32'(wa_q.size()), 32'd2);
        check("t6_addr0", 32'(wa_q[0]), 32'd0);
        check("t6_data0", wd_q[0], 32'h12345678);
        check("t6_addr1", 32'(wa_q[1]), 32'd1);
        check("t6_data1", wd_q[1], 32'h9ABCDEF0);

`ifdef LOADER_CHECKSUM_EN
        pulse_reload();
        start_frame(16'd1);
        send_word(32'h00000013);
        send_byte(8'h12);
        check("t7_good_done",  {31'b0, done},  32'd1);
        check("t7_good_error", {31'b0, error}, 32'd0);
        pulse_reload();
        start_frame(16'd1);
        send_word(32'h00000013);
        send_byte(8'h00);
        check("t7_bad_error",    {31'b0, error},    32'd1);
        check("t7_bad_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("t7_bad_done",     {31'b0, done},     32'd0);
        pulse_reload();
        check("t7_rl_in_ready", {31'b0, in_ready}, 32'd1);
        check("t7_rl_error",    {31'b0, error},    32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
